// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target endpoint: mode encodings, byte type,
// slot state encoding and CPOL/CPHA extraction.
package spi_pkg;

    localparam int unsigned SPI_MODE0 = 0;
    localparam int unsigned SPI_MODE1 = 1;
    localparam int unsigned SPI_MODE2 = 2;
    localparam int unsigned SPI_MODE3 = 3;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } slot_state_e;

    // SCK idle level.
    function automatic logic get_cpol(input int unsigned mode);
        return (mode == SPI_MODE2) || (mode == SPI_MODE3);
    endfunction

    // 1 = sample on the trailing edge.
    function automatic logic get_cpha(input int unsigned mode);
        return (mode == SPI_MODE1) || (mode == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Host-side byte handshake of the SPI target: received-byte strobe and the
// TX preload strobe, both in the i_Clk domain.
interface spi_slave_if;
    import spi_pkg::*;

    logic  o_RX_DV;
    byte_t o_RX_Byte;
    logic  i_TX_DV;
    byte_t i_TX_Byte;

    modport slave (
        output o_RX_DV,
        output o_RX_Byte,
        input  i_TX_DV,
        input  i_TX_Byte
    );

    modport master (
        input  o_RX_DV,
        input  o_RX_Byte,
        output i_TX_DV,
        output i_TX_Byte
    );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer bringing one asynchronous SPI pin into i_Clk;
// the reset value is chosen per pin so the bus looks idle out of reset.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: flops are written with <= so both stages sample their inputs
    // from before the edge, giving a true two-stage pipeline.
    always_ff @(posedge i_Clk or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples SCK/MOSI/CS_n on i_Clk, assembles MSB-first
// RX bytes and shifts a preloaded TX byte out on MISO in the same byte slot.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE = SPI_MODE0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,     // active-high despite the suffix
    spi_slave_if.slave bus,
    input  logic       i_SPI_Clk,
    output wire        o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    localparam logic CPOL = get_cpol(SPI_MODE);
    localparam logic CPHA = get_cpha(SPI_MODE);

    logic w_sck;
    logic w_mosi;
    logic w_cs_n;

    spi_sync #(.RST_VAL(CPOL)) u_sync_sck (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_d     (i_SPI_Clk),
        .o_q     (w_sck)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_d     (i_SPI_MOSI),
        .o_q     (w_mosi)
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_d     (i_SPI_CS_n),
        .o_q     (w_cs_n)
    );

    // SCK edge detection
    logic r_sck_d;
    logic w_sck_edge;
    logic w_lead;
    logic w_trail;
    logic w_sample;
    logic w_shift;

    always_ff @(posedge i_Clk or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            r_sck_d <= CPOL;
        end else begin
            r_sck_d <= w_sck;
        end
    end

    assign w_sck_edge = w_sck ^ r_sck_d;
    assign w_lead     = w_sck_edge & (r_sck_d == CPOL);
    assign w_trail    = w_sck_edge & (r_sck_d != CPOL);
    assign w_sample   = CPHA ? w_trail : w_lead;
    assign w_shift    = CPHA ? w_lead  : w_trail;

    // Slot FSM: tracks selection so the CS_n falling edge can open a TX slot
    slot_state_e r_state;
    slot_state_e w_next_state;
    logic        w_slot_start;

    always_ff @(posedge i_Clk or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_slot_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_n) begin
                    w_next_state = ST_ACTIVE;
                    w_slot_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_n) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // RX path: the first seven bits wait here; the eighth completes the byte
    logic [BYTE_W-2:0] r_rx_shift;
    logic [2:0]        r_bit_cnt;
    logic              r_rx_dv;
    byte_t             r_rx_byte;

    always_ff @(posedge i_Clk or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_rx_dv    <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_dv <= 1'b0;
            if (w_cs_n) begin
                r_rx_shift <= '0;
                r_bit_cnt  <= '0;
            end else if (w_sample) begin
                r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_byte <= {r_rx_shift, w_mosi};
                    r_rx_dv   <= 1'b1;
                end
            end
        end
    end

    assign bus.o_RX_DV   = r_rx_dv;
    assign bus.o_RX_Byte = r_rx_byte;

    // TX path. A shift edge seen while the bit counter is zero belongs to the
    // slot boundary: it either presents the MSB (CPHA=1) or trails the last
    // bit of the previous byte (CPHA=0), so the register must not advance.
    byte_t r_tx_preload;
    byte_t r_tx_shift;
    logic  w_tx_load;
    byte_t w_tx_src;

    assign w_tx_load = w_slot_start | (r_rx_dv & ~w_cs_n);
    assign w_tx_src  = bus.i_TX_DV ? bus.i_TX_Byte : r_tx_preload;

    always_ff @(posedge i_Clk or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            r_tx_preload <= '0;
            r_tx_shift   <= '0;
        end else begin
            if (bus.i_TX_DV) begin
                r_tx_preload <= bus.i_TX_Byte;
            end
            if (w_tx_load) begin
                r_tx_shift <= w_tx_src;
            end else if (w_shift && !w_cs_n && (r_bit_cnt != 3'd0)) begin
                r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign o_SPI_MISO = w_cs_n ? 1'bz : r_tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-banged master per
// instance, and a queue-based scoreboard checking every o_RX_DV pulse.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int H = 4;   // half SCK period in i_Clk cycles (i_Clk = 8x SCK)

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus per mode instance
    logic [3:0] r_sck   = 4'b1100;   // each instance idles at its CPOL
    logic [3:0] r_mosi  = 4'b0000;
    logic [3:0] r_cs_n  = 4'b1111;
    logic [3:0] r_tx_dv = 4'b0000;
    logic [7:0] r_tx_byte [4];

    logic [3:0] w_rx_dv;
    logic [3:0] w_miso;
    logic [3:0] w_miso_z;
    logic [7:0] w_rx_byte [4];

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave_if u_if ();
        wire w_miso_net;

        assign u_if.i_TX_DV   = r_tx_dv[m];
        assign u_if.i_TX_Byte = r_tx_byte[m];
        assign w_rx_dv[m]     = u_if.o_RX_DV;
        assign w_rx_byte[m]   = u_if.o_RX_Byte;
        assign w_miso[m]      = w_miso_net;
        assign w_miso_z[m]    = (w_miso_net === 1'bz);

        spi_slave #(.SPI_MODE(m)) u_dut (
            .i_Clk      (clk),
            .i_Rst_L    (rst),
            .bus        (u_if.slave),
            .i_SPI_Clk  (r_sck[m]),
            .o_SPI_MISO (w_miso_net),
            .i_SPI_MOSI (r_mosi[m]),
            .i_SPI_CS_n (r_cs_n[m])
        );
    end

    // Scoreboard
    typedef struct {
        int         mode;
        logic [7:0] data;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   mon_lat;
    int   last8_cyc = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_rx(input int m, input logic [7:0] d);
        exp_t e;
        e.mode = m;
        e.data = d;
        q_exp.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (w_rx_dv[m]) begin
                if (q_exp.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rx_dv: mode %0d byte 0x%02h, no pulse expected (t=%0t)",
                             m, w_rx_byte[m], $time);
                end else begin
                    mon_e   = q_exp.pop_front();
                    mon_lat = cyc - last8_cyc;
                    check($sformatf("rx_mode_m%0d", m), 8'(m), 8'(mon_e.mode));
                    check($sformatf("rx_byte_m%0d", m), w_rx_byte[m], mon_e.data);
                    check($sformatf("rx_latency_in_3_to_4_lat%0d", mon_lat),
                          {7'b0, (mon_lat >= 3 && mon_lat <= 4)}, 8'd1);
                end
            end
        end
    end

    // Master-side helpers
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input int m, input logic [7:0] b);
        @(negedge clk);
        r_tx_dv[m]   = 1'b1;
        r_tx_byte[m] = b;
        @(negedge clk);
        r_tx_dv[m]   = 1'b0;
    endtask

    task automatic cs_low(input int m);
        r_cs_n[m] = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic cs_high(input int m);
        wait_clk(H);
        r_cs_n[m] = 1'b1;
        wait_clk(2 * H);
    endtask

    // Sends the top nbits of tx MSB-first, returns what was seen on MISO.
    task automatic spi_byte(input int m, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        logic cpol;
        logic cpha;
        cpol = ((m >> 1) & 1) != 0;
        cpha = (m & 1) != 0;
        rx   = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                r_mosi[m] = tx[7-i];
                wait_clk(H);
                r_sck[m] = ~cpol;
                rx = {rx[6:0], w_miso[m]};
                if (i == 7) last8_cyc = cyc;
                wait_clk(H);
                r_sck[m] = cpol;
            end else begin
                r_sck[m]  = ~cpol;
                r_mosi[m] = tx[7-i];
                wait_clk(H);
                r_sck[m] = cpol;
                rx = {rx[6:0], w_miso[m]};
                if (i == 7) last8_cyc = cyc;
                wait_clk(H);
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 8'(q_exp.size()), 8'd0);
        q_exp.delete();
    endtask

    // Answers the first o_RX_DV of mode 0 with a same-cycle TX strobe.
    task automatic host_reply(input logic [7:0] b);
        int n;
        n = 0;
        while (!w_rx_dv[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        r_tx_dv[0]   = 1'b1;
        r_tx_byte[0] = b;
        @(negedge clk);
        r_tx_dv[0]   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] rx_a;
    logic [7:0] rx_b;

    initial begin
        for (int m = 0; m < 4; m++) r_tx_byte[m] = 8'h00;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);

        // Reset state of every instance
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset_rx_dv_m%0d", m),   {7'b0, w_rx_dv[m]}, 8'd0);
            check($sformatf("reset_rx_byte_m%0d", m), w_rx_byte[m], 8'h00);
            check($sformatf("reset_miso_z_m%0d", m),  {7'b0, w_miso_z[m]}, 8'd1);
        end

        // Mode 0, 0xAA; preload still at its reset value
        cs_low(0);
        expect_rx(0, 8'hAA);
        spi_byte(0, 8'hAA, 8, rx_a);
        cs_high(0);
        check("m0_aa_miso_reset_preload", rx_a, 8'h00);
        drain("m0_aa_drain");

        // Preloaded 0x3C answers 0x77
        preload(0, 8'h3C);
        cs_low(0);
        expect_rx(0, 8'h77);
        spi_byte(0, 8'h77, 8, rx_a);
        cs_high(0);
        check("m0_tx_3c", rx_a, 8'h3C);
        drain("m0_77_drain");

        // Back-to-back bytes, host reloads in the o_RX_DV cycle of byte 1
        preload(0, 8'hE1);
        cs_low(0);
        expect_rx(0, 8'h66);
        expect_rx(0, 8'h00);
        fork
            begin
                spi_byte(0, 8'h66, 8, rx_a);
                spi_byte(0, 8'h00, 8, rx_b);
            end
            host_reply(8'h5A);
        join
        cs_high(0);
        check("b2b_byte1_miso", rx_a, 8'hE1);
        check("b2b_byte2_miso_bypass", rx_b, 8'h5A);
        drain("b2b_drain");

        // CS_n raised after 5 bits, then a full byte; preload 0x5A is re-sent
        cs_low(0);
        spi_byte(0, 8'hFF, 5, rx_a);
        cs_high(0);
        check("abort_miso_z", {7'b0, w_miso_z[0]}, 8'd1);
        cs_low(0);
        expect_rx(0, 8'h99);
        spi_byte(0, 8'h99, 8, rx_a);
        cs_high(0);
        check("abort_then_99_miso_resend", rx_a, 8'h5A);
        drain("abort_drain");

        // Reset in the middle of a byte
        cs_low(0);
        spi_byte(0, 8'hF0, 5, rx_a);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("midrst_rx_byte", w_rx_byte[0], 8'h00);
        check("midrst_rx_dv", {7'b0, w_rx_dv[0]}, 8'd0);
        cs_high(0);
        check("midrst_miso_z", {7'b0, w_miso_z[0]}, 8'd1);
        cs_low(0);
        expect_rx(0, 8'h4E);
        spi_byte(0, 8'h4E, 8, rx_a);
        cs_high(0);
        check("midrst_next_miso_preload_cleared", rx_a, 8'h00);
        drain("midrst_drain");

        // Modes 1..3: receive 0xC3 while returning preloaded 0x81
        for (int m = 1; m < 4; m++) begin
            check($sformatf("mode%0d_miso_z_before", m), {7'b0, w_miso_z[m]}, 8'd1);
            preload(m, 8'h81);
            cs_low(m);
            check($sformatf("mode%0d_miso_driven", m), {7'b0, w_miso_z[m]}, 8'd0);
            expect_rx(m, 8'hC3);
            spi_byte(m, 8'hC3, 8, rx_a);
            cs_high(m);
            check($sformatf("mode%0d_miso_81", m), rx_a, 8'h81);
            check($sformatf("mode%0d_miso_z_after", m), {7'b0, w_miso_z[m]}, 8'd1);
            drain($sformatf("mode%0d_drain", m));
        end

        wait_clk(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) endpoint that bridges an external SPI bus into the system clock domain.
- Receives bytes MSB-first on MOSI and presents each one as a one-cycle valid pulse on i_Clk.
- Shifts a byte preloaded by the host logic out on MISO during the next byte slot.
- Used by the diagnostics controller for command/response byte exchange with an external SPI master.

Parameters:
- SPI_MODE, default 0: SPI mode 0-3. CPOL = SPI_MODE[1] is the SCK idle level. CPHA = SPI_MODE[0]; when 0, sample on the leading edge.

Ports:
- i_Clk  in  1  system clock; all logic runs on its rising edge.
- i_Rst_L  in  1  asynchronous reset, ACTIVE-HIGH. The name is kept for codebase compatibility; the polarity is high despite the suffix.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte holds a newly received byte.
- o_RX_Byte  out  8  last received byte; holds until the next o_RX_DV.
- i_TX_DV  in  1  one-cycle strobe that loads i_TX_Byte into the TX preload register.
- i_TX_Byte  in  8  byte to transmit in the next byte slot.
- i_SPI_Clk  in  1  SCK from the master, asynchronous to i_Clk.
- o_SPI_MISO  out  1  serial data out; high-Z while CS_n is high.
- i_SPI_MOSI  in  1  serial data in, asynchronous.
- i_SPI_CS_n  in  1  active-low chip select, asynchronous.

Behaviour:
- Single-clock design: SCK, MOSI and CS_n each pass through a 2-FF synchronizer into i_Clk. SCK gets one extra delay flop for edge detection.
- Requirement: i_Clk frequency >= 4x SCK frequency. The master holds MOSI stable at least 3 i_Clk cycles around each sample edge.
- Edge definitions:
  - Leading edge = SCK transition away from CPOL; trailing edge = transition back.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other one.
- RX path:
  - On each detected sample edge with CS_n (synced) low, shift synced MOSI into the RX shift register, MSB first, and increment a 3-bit counter.
  - On the 8th sample edge:
    - the completed byte is written to o_RX_Byte;
    - o_RX_DV is high for exactly the next i_Clk cycle;
    - the counter wraps to 0.
  - Latency from the 8th SCK sample edge to o_RX_DV is 3-4 i_Clk cycles.
- TX preload:
  - i_TX_DV=1 writes i_TX_Byte to the preload register.
  - The preload register is retained until rewritten, so an unreloaded slot re-sends the old value.
- TX load point: the TX shift register loads from preload at the start of each byte slot:
  - CS_n synced falling edge;
  - the cycle o_RX_DV is asserted, when CS_n stays low for back-to-back bytes.
  - If i_TX_DV is high in that same cycle, i_TX_Byte is loaded directly (bypass).
- MISO output:
  - CPHA=0: the MSB drives MISO immediately on load; each shift edge advances to the next bit.
  - CPHA=1: the first shift (leading) edge presents the MSB; subsequent shift edges advance.
  - o_SPI_MISO = current TX bit while CS_n (synced) is low, else 'z'.
- CS_n high mid-byte: the bit counter is cleared, the partial RX byte is discarded (no o_RX_DV), and the TX slot restarts at the next CS_n falling edge.
- Reset (async assert, synchronous release) values:
  - o_RX_DV=0, o_RX_Byte=0x00;
  - preload=0x00, shift registers=0x00, counter=0;
  - synchronizer CS_n stages=1 (deselected) and SCK stages=CPOL, so MISO is high-Z.
  - Reset mid-transfer aborts the byte with no o_RX_DV.

Decomposition:
- Shared package spi_pkg: SPI mode constants (MODE0..MODE3), byte width 8, and a CPOL/CPHA extraction function.
- One sub-module, spi_sync: a parameterized 2-FF synchronizer (reset value as a parameter), instantiated for SCK, MOSI and CS_n.

Test Plan:
- Mode 0, CS_n low, master sends 0xAA (i_Clk = 8x SCK) -> exactly one o_RX_DV pulse, o_RX_Byte=0xAA, within 4 cycles of the 8th rising SCK.
- i_TX_DV with 0x3C before the frame, master sends 0x77 -> master captures 0x3C on MISO, MSB first; slave receives 0x77.
- Back-to-back bytes 0x66, 0x00 in one CS_n frame; host loads 0x5A in the o_RX_DV cycle of byte 1 -> MISO returns 0x5A in byte 2; two o_RX_DV pulses (0x66, 0x00).
- CS_n raised after 5 bits, then a full byte 0x99 -> no pulse for the partial byte; one pulse with 0x99.
- Modes 1/2/3 each sending 0xC3 with 0x81 preloaded -> RX=0xC3, MISO=0x81; MISO high-Z whenever CS_n=1.
- i_Rst_L=1 asserted mid-byte -> o_RX_DV stays 0, o_RX_Byte=0x00; the next full byte after release is received correctly.
